// File: rtl/dmi_host_initiator.sv
// DMI types shared by the debug transport and debug module.
package dm;
    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;
endpackage

// DTM-side DMI initiator: one host command in flight, registered result held until consumed.
// Request issues the cycle after accept; dmi_req held stable under DM backpressure; response timeout reports busy.
module dmi_host_initiator #(
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [1:0]      cmd_op_i,
    input  logic [6:0]      cmd_addr_i,
    input  logic [31:0]     cmd_data_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [31:0]     res_data_o,
    output logic [1:0]      res_status_o,
    output logic [1:0]      dmistat_o,
    input  logic            dmireset_i,
    input  logic            dmihardreset_i,
    output logic            dmi_rst_no,
    output logic            dmi_req_valid_o,
    input  logic            dmi_req_ready_i,
    output dm::dmi_req_t    dmi_req_o,
    input  logic            dmi_resp_valid_i,
    output logic            dmi_resp_ready_o,
    input  dm::dmi_resp_t   dmi_resp_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e                state_q, state_d;
    dm::dmi_req_t          req_q, req_d;
    logic [31:0]           res_data_q, res_data_d;
    logic [1:0]            res_status_q, res_status_d;
    logic                  res_valid_q, res_valid_d;
    logic [1:0]            dmistat_q, dmistat_d;
    logic                  timed_out_q, timed_out_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  dmi_rst_n_q;

    logic                  cmd_accept;
    logic                  resp_hs;
    logic                  res_hs;
    logic                  in_flight;
    logic                  timeout_hit;

    assign cmd_ready_o      = (state_q == IDLE) && dmi_rst_n_q;
    assign cmd_accept       = cmd_valid_i && cmd_ready_o;
    assign resp_hs          = (state_q == RESP) && dmi_resp_valid_i;
    assign res_hs           = res_valid_q && res_ready_i;
    assign in_flight        = (state_q == REQ) || (state_q == RESP);
    // A response landing on the deadline cycle completes normally.
    assign timeout_hit      = in_flight && !timed_out_q && !resp_hs &&
                              (cnt_q == CntWidth'(TimeoutCycles - 1));

    assign dmi_req_valid_o  = (state_q == REQ);
    assign dmi_resp_ready_o = (state_q == RESP);
    assign dmi_req_o        = req_q;
    assign res_valid_o      = res_valid_q;
    assign res_data_o       = res_data_q;
    assign res_status_o     = res_status_q;
    assign dmistat_o        = dmistat_q;
    assign dmi_rst_no       = dmi_rst_n_q;

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
        res_valid_d  = res_valid_q;
        dmistat_d    = dmistat_q;
        timed_out_d  = timed_out_q;
        cnt_d        = cnt_q;

        // Clearing the sticky error loses to any update in the same cycle.
        if (dmireset_i) begin
            dmistat_d = 2'd0;
        end
        if (res_hs) begin
            res_valid_d = 1'b0;
        end
        if (in_flight && !timed_out_q) begin
            cnt_d = cnt_q + CntWidth'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    timed_out_d = 1'b0;
                    if (dm::dtm_op_e'(cmd_op_i) == dm::DTM_NOP) begin
                        state_d      = HOLD;
                        res_valid_d  = 1'b1;
                        res_data_d   = 32'd0;
                        res_status_d = 2'd0;
                    end else if (dmistat_q != 2'd0) begin
                        state_d      = HOLD;
                        res_valid_d  = 1'b1;
                        res_data_d   = 32'd0;
                        res_status_d = dmistat_q;
                    end else begin
                        state_d    = REQ;
                        req_d.addr = cmd_addr_i;
                        req_d.op   = dm::dtm_op_e'(cmd_op_i);
                        req_d.data = cmd_data_i;
                        cnt_d      = '0;
                    end
                end
            end
            REQ: begin
                if (dmi_req_ready_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_hs) begin
                    if (timed_out_q) begin
                        // Late response is dropped; wait only for the busy result to drain.
                        state_d = (res_valid_q && !res_ready_i) ? HOLD : IDLE;
                    end else begin
                        state_d      = HOLD;
                        res_valid_d  = 1'b1;
                        res_data_d   = (req_q.op == dm::DTM_READ) ? dmi_resp_i.data : 32'd0;
                        res_status_d = dmi_resp_i.resp;
                        if (dmi_resp_i.resp != 2'd0 && dmistat_q == 2'd0) begin
                            dmistat_d = dmi_resp_i.resp;
                        end
                    end
                end
            end
            HOLD: begin
                if (res_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout_hit) begin
            timed_out_d  = 1'b1;
            dmistat_d    = 2'd3;
            res_valid_d  = 1'b1;
            res_data_d   = 32'd0;
            res_status_d = 2'd3;
        end

        if (dmihardreset_i) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
            dmistat_d   = 2'd0;
            timed_out_d = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            req_q        <= '0;
            res_data_q   <= 32'd0;
            res_status_q <= 2'd0;
            res_valid_q  <= 1'b0;
            dmistat_q    <= 2'd0;
            timed_out_q  <= 1'b0;
            cnt_q        <= '0;
            dmi_rst_n_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
            res_valid_q  <= res_valid_d;
            dmistat_q    <= dmistat_d;
            timed_out_q  <= timed_out_d;
            cnt_q        <= cnt_d;
            dmi_rst_n_q  <= !dmihardreset_i;
        end
    end

endmodule

// File: tb/tb_dmi_host_initiator.sv
// Directed bench for dmi_host_initiator with TimeoutCycles = 8.
module tb_dmi_host_initiator;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [6:0]    cmd_addr_i;
    logic [31:0]   cmd_data_i;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [31:0]   res_data_o;
    logic [1:0]    res_status_o;
    logic [1:0]    dmistat_o;
    logic          dmireset_i;
    logic          dmihardreset_i;
    logic          dmi_rst_no;
    logic          dmi_req_valid_o;
    logic          dmi_req_ready_i;
    dm::dmi_req_t  dmi_req_o;
    logic          dmi_resp_valid_i;
    logic          dmi_resp_ready_o;
    dm::dmi_resp_t dmi_resp_i;

    int n_tests = 0;
    int n_fail  = 0;

    dmi_host_initiator #(.TimeoutCycles(8)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_op_i         (cmd_op_i),
        .cmd_addr_i       (cmd_addr_i),
        .cmd_data_i       (cmd_data_i),
        .res_valid_o      (res_valid_o),
        .res_ready_i      (res_ready_i),
        .res_data_o       (res_data_o),
        .res_status_o     (res_status_o),
        .dmistat_o        (dmistat_o),
        .dmireset_i       (dmireset_i),
        .dmihardreset_i   (dmihardreset_i),
        .dmi_rst_no       (dmi_rst_no),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_o        (dmi_req_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_i       (dmi_resp_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        int n = 0;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        while (!cmd_ready_o && n < 50) begin
            step();
            n++;
        end
        if (!cmd_ready_o) check("cmd_ready_wait", 64'(cmd_ready_o), 64'd1);
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic dm_respond(input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        while (!dmi_resp_ready_o && n < 50) begin
            step();
            n++;
        end
        if (!dmi_resp_ready_o) check("resp_ready_wait", 64'(dmi_resp_ready_o), 64'd1);
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i.data  = data;
        dmi_resp_i.resp  = resp;
        step();
        dmi_resp_valid_i = 1'b0;
    endtask

    task automatic finish_result(input string tag, input logic [31:0] data, input logic [1:0] status);
        int n = 0;
        while (!res_valid_o && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 64'(res_valid_o), 64'd1);
        check({tag, "_data"}, 64'(res_data_o), 64'(data));
        check({tag, "_status"}, 64'(res_status_o), 64'(status));
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        check({tag, "_drained"}, 64'(res_valid_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i            = 1'b1;
        cmd_valid_i      = 1'b0;
        cmd_op_i         = 2'd0;
        cmd_addr_i       = 7'd0;
        cmd_data_i       = 32'd0;
        res_ready_i      = 1'b0;
        dmireset_i       = 1'b0;
        dmihardreset_i   = 1'b0;
        dmi_req_ready_i  = 1'b1;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '0;

        // Reset values
        repeat (2) step();
        check("rst_dmi_rst_no", 64'(dmi_rst_no), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        check("rst_res_valid", 64'(res_valid_o), 64'd0);
        check("rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
        check("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        check("rst_req", 64'(dmi_req_o), 64'd0);
        check("rst_dmistat", 64'(dmistat_o), 64'd0);
        rst_i = 1'b0;
        check("rst_release_pre", 64'(dmi_rst_no), 64'd0);
        step();
        check("rst_release_post", 64'(dmi_rst_no), 64'd1);
        check("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);

        // Write, DM ready immediately
        send_cmd(2'd2, 7'h10, 32'h0000_0001);
        check("wr_req_valid", 64'(dmi_req_valid_o), 64'd1);
        check("wr_req", 64'(dmi_req_o), 64'({7'h10, 2'd2, 32'h0000_0001}));
        check("wr_cmd_ready_busy", 64'(cmd_ready_o), 64'd0);
        step();
        check("wr_req_one_cycle", 64'(dmi_req_valid_o), 64'd0);
        check("wr_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
        dm_respond(32'h5555_5555, 2'd0);
        finish_result("wr_res", 32'd0, 2'd0);
        check("wr_dmistat", 64'(dmistat_o), 64'd0);

        // Read with DM backpressure for three cycles
        dmi_req_ready_i = 1'b0;
        send_cmd(2'd1, 7'h11, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("rd_bp_valid", 64'(dmi_req_valid_o), 64'd1);
            check("rd_bp_req", 64'(dmi_req_o), 64'({7'h11, 2'd1, 32'h0}));
            if (i == 3) dmi_req_ready_i = 1'b1;
            step();
        end
        check("rd_bp_in_resp", 64'(dmi_resp_ready_o), 64'd1);
        dm_respond(32'hDEAD_BEEF, 2'd0);
        finish_result("rd_res", 32'hDEAD_BEEF, 2'd0);

        // Failure is sticky until dmireset
        send_cmd(2'd1, 7'h12, 32'h0);
        dm_respond(32'h1234_5678, 2'd2);
        finish_result("fail_res", 32'h1234_5678, 2'd2);
        check("fail_dmistat", 64'(dmistat_o), 64'd2);
        send_cmd(2'd2, 7'h12, 32'hFFFF_0000);
        check("sticky_no_req", 64'(dmi_req_valid_o), 64'd0);
        finish_result("sticky_res", 32'd0, 2'd2);
        dmireset_i = 1'b1;
        step();
        dmireset_i = 1'b0;
        check("dmireset_clear", 64'(dmistat_o), 64'd0);
        send_cmd(2'd2, 7'h12, 32'hFFFF_0000);
        check("post_clear_req", 64'(dmi_req_o), 64'({7'h12, 2'd2, 32'hFFFF_0000}));
        dm_respond(32'h0, 2'd0);
        finish_result("post_clear_res", 32'd0, 2'd0);

        // Timeout: accepted but no response; late response discarded
        send_cmd(2'd1, 7'h13, 32'h0);
        for (int i = 0; i < 7; i++) begin
            step();
            check("to_not_yet", 64'(res_valid_o), 64'd0);
        end
        step();
        check("to_res_valid", 64'(res_valid_o), 64'd1);
        check("to_status", 64'(res_status_o), 64'd3);
        check("to_data", 64'(res_data_o), 64'd0);
        check("to_dmistat", 64'(dmistat_o), 64'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_cmd_ready_low", 64'(cmd_ready_o), 64'd0);
        end
        dm_respond(32'hBAD0_BAD0, 2'd2);
        check("late_dmistat", 64'(dmistat_o), 64'd3);
        check("late_status", 64'(res_status_o), 64'd3);
        check("late_data", 64'(res_data_o), 64'd0);
        check("late_cmd_ready", 64'(cmd_ready_o), 64'd0);
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        check("late_no_second", 64'(res_valid_o), 64'd0);
        check("late_idle", 64'(cmd_ready_o), 64'd1);
        dmireset_i = 1'b1;
        step();
        dmireset_i = 1'b0;
        check("to_dmireset", 64'(dmistat_o), 64'd0);

        // Hardreset mid-RESP with a pending busy result
        send_cmd(2'd1, 7'h14, 32'h0);
        repeat (9) step();
        check("hr_pre_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
        check("hr_pre_dmistat", 64'(dmistat_o), 64'd3);
        dmihardreset_i = 1'b1;
        step();
        dmihardreset_i = 1'b0;
        check("hr_rst_low", 64'(dmi_rst_no), 64'd0);
        check("hr_cmd_ready", 64'(cmd_ready_o), 64'd0);
        check("hr_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        check("hr_req_valid", 64'(dmi_req_valid_o), 64'd0);
        check("hr_res_valid", 64'(res_valid_o), 64'd0);
        check("hr_dmistat", 64'(dmistat_o), 64'd0);
        step();
        check("hr_rst_high", 64'(dmi_rst_no), 64'd1);
        check("hr_cmd_ready_back", 64'(cmd_ready_o), 64'd1);
        check("hr_no_result", 64'(res_valid_o), 64'd0);
        send_cmd(2'd1, 7'h15, 32'h0);
        check("hr_next_req", 64'(dmi_req_o), 64'({7'h15, 2'd1, 32'h0}));
        dm_respond(32'hCAFE_F00D, 2'd0);
        finish_result("hr_next_res", 32'hCAFE_F00D, 2'd0);

        // NOP offered while a result is pending
        send_cmd(2'd2, 7'h16, 32'h0000_00AA);
        dm_respond(32'h0, 2'd0);
        cmd_valid_i = 1'b1;
        cmd_op_i    = 2'd0;
        cmd_addr_i  = 7'h7F;
        for (int i = 0; i < 5; i++) begin
            check("nop_cmd_ready_low", 64'(cmd_ready_o), 64'd0);
            check("nop_pending_valid", 64'(res_valid_o), 64'd1);
            step();
        end
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        check("nop_idle_ready", 64'(cmd_ready_o), 64'd1);
        step();
        cmd_valid_i = 1'b0;
        check("nop_no_req", 64'(dmi_req_valid_o), 64'd0);
        check("nop_no_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        finish_result("nop_res", 32'd0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmi_host_initiator.md
Name: dmi_host_initiator

Overview:
- DTM-side initiator of the Debug Module Interface (DMI).
- Takes single register-level commands (NOP/read/write, 7-bit address, 32-bit data) from a host front end (JTAG TAP logic or a test controller) and drives the DM's dmi_req/dmi_resp valid/ready handshakes.
- Returns each result with a status code.
- Keeps a sticky error (dmistat-style), runs a response timeout, and generates the DMI-side reset.

Parameters:
- TimeoutCycles, 1024: cycles from entering REQ until a missing response is declared busy/timeout. Minimum 2.
- CntWidth, $clog2(TimeoutCycles+1): width of the timeout counter. Derived; not overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cmd_valid_i  in  1  host command valid
- cmd_ready_o  out  1  command accepted
- cmd_op_i  in  2  dm::dtm_op_e encoding: 0 NOP, 1 read, 2 write
- cmd_addr_i  in  7  DMI register address
- cmd_data_i  in  32  write data
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed
- res_data_o  out  32  read data (0 for NOP/write)
- res_status_o  out  2  0 success, 2 failed, 3 busy/timeout
- dmistat_o  out  2  sticky error
- dmireset_i  in  1  one-cycle pulse; clears sticky error
- dmihardreset_i  in  1  one-cycle pulse; aborts transaction and pulses DMI reset
- dmi_rst_no  out  1  DMI reset to DM, active-low
- dmi_req_valid_o  out  1  request valid
- dmi_req_ready_i  in  1  DM ready
- dmi_req_o  out  dm::dmi_req_t  {addr, op, data}
- dmi_resp_valid_i  in  1  response valid
- dmi_resp_ready_o  out  1  initiator ready
- dmi_resp_i  in  dm::dmi_resp_t  {data, resp}

Behaviour:
- Reset values: all outputs 0, including dmi_rst_no (DM held in DMI reset). dmi_rst_no rises in the first clock edge after rst_i deasserts.
- FSM states: IDLE, REQ, RESP, HOLD.
- IDLE:
  - cmd_ready_o = 1.
  - Accept on cmd_valid_i & cmd_ready_o.
  - NOP: go to HOLD, status 0, data 0, no DMI activity.
  - dmistat != 0 at accept: go to HOLD, status = dmistat, data 0, no DMI activity.
  - Otherwise: register addr/op/data and go to REQ.
- REQ:
  - dmi_req_valid_o = 1; dmi_req_o is stable until dmi_req_ready_i.
  - Valid is never withdrawn except by hardreset.
  - On handshake, go to RESP.
- RESP:
  - dmi_resp_ready_o = 1.
  - On dmi_resp_valid_i, capture data and resp, then go to HOLD.
  - Result data = resp.data if op was read, else 0.
  - resp != 0 sets dmistat = resp when dmistat == 0.
- HOLD:
  - res_valid_o = 1; outputs stable until res_ready_i.
  - Go to IDLE on res_ready_i.
  - cmd_ready_o = 0 in REQ, RESP and HOLD, so at most one command is outstanding.
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ/RESP.
  - When count == TimeoutCycles-1 with no completing handshake: dmistat = 3 and timed_out flag set.
  - Result (status 3, data 0) is presented on res_valid_o in parallel with the ongoing transaction.
  - FSM continues REQ/RESP and discards the eventual response: no dmistat update, no second result.
  - After both the transaction completes and the result is consumed, go to IDLE.
  - If the response arrives in the same cycle the timeout fires, the response wins and there is no timeout.
- dmireset_i: clears dmistat next cycle. If an update occurs in the same cycle, the update wins.
- dmihardreset_i (any state):
  - Next cycle: FSM goes to IDLE; dmi_req_valid_o, dmi_resp_ready_o and res_valid_o drop; dmistat, timed_out and the counter clear; no result is emitted.
  - dmi_rst_no = 0 for exactly one cycle.
  - cmd_ready_o = 0 during that cycle.
- rst_i mid-transaction: immediate asynchronous return to reset values.
- Request fields: op passed through unchanged; addr zero-extended to dm::dmi_req_t addr width.

Test Plan:
- Write: cmd op=2 addr=0x10 data=0x00000001, DM ready immediately, resp=0 -> one-cycle dmi_req with {0x10,2,0x1}; result status 0, data 0; dmistat 0.
- Read with backpressure: dmi_req_ready_i low 3 cycles, then response data=0xDEADBEEF -> dmi_req_o stable all 4 cycles; result data 0xDEADBEEF, status 0.
- Failure sticky: DM resp=2 on read -> status 2, dmistat 2. Next write -> immediate status 2, no dmi_req_valid_o. After dmireset_i pulse, write succeeds.
- Timeout (TimeoutCycles=8): DM accepts but withholds response -> result status 3 after 8 cycles in REQ/RESP, dmistat 3. Late response at cycle 12 is discarded. cmd_ready_o stays 0 until then.
- Hardreset mid-RESP: dmihardreset_i pulse -> dmi_rst_no low 1 cycle; valids drop; no result; dmistat 0; next command issues normally.
- NOP while result pending: hold res_ready_i low 5 cycles -> cmd_ready_o 0 throughout; NOP result status 0, data 0, no DMI traffic.
